axis_framer: RTL and testbench

- Upstream framing stage for the team's AXI4-Stream interfaces.
- Accepts a continuous sample stream with no frame structure (valid/ready/data only) and emits axi4s MANAGER-side beats.
- Inserts tlast every frame_len beats, or early on a flush request.
- Drives tkeep/tstrb all-ones.
- Registered output with a 2-entry skid buffer, so throughput is 1 beat/cycle with no combinational ready path.

---
 rtl/axis_framer.sv | 125 ++++++++++++
 tb/tb_axis_framer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_framer.sv
// axis_framer: cuts a flat AXI-Stream into frames of frame_len beats (or early on flush) behind a 2-entry registered skid buffer.
// Optional: define AXIS_FRAMER_TUSER_SOF_EN to add m_tuser marking the first beat of each frame.
module axis_framer #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 flush,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [WIDTH-1:0]     s_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [WIDTH-1:0]     m_tdata,
    output logic                 m_tlast,
    output logic [WIDTH/8-1:0]   m_tkeep,
    output logic [WIDTH/8-1:0]   m_tstrb,
`ifdef AXIS_FRAMER_TUSER_SOF_EN
    output logic                 m_tuser,
`endif
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
`ifdef AXIS_FRAMER_TUSER_SOF_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH + 1;
`endif

    logic [0:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
    logic                 pend_q, pend_d, rdy_q, rdy_d;
    logic [1:0]           cnt_q, cnt_d, wr_idx;
    logic [EW-1:0]        e0_q, e0_d, e1_q, e1_d, entry_in;
    logic [CNT_WIDTH-1:0] fc_q, fc_d;
    logic                 push, pop, last_in;

    assign push     = s_tvalid && rdy_q;
    assign pop      = m_tvalid && m_tready;
    assign last_in  = (beat_q == len_q - ONE) || pend_q || flush;
`ifdef AXIS_FRAMER_TUSER_SOF_EN
    assign entry_in = {beat_q == '0, last_in, s_tdata};
    assign m_tuser  = e0_q[WIDTH+1];
`else
    assign entry_in = {last_in, s_tdata};
`endif
    assign s_tready    = rdy_q;
    assign m_tvalid    = cnt_q != 2'd0;
    assign m_tdata     = e0_q[WIDTH-1:0];
    assign m_tlast     = e0_q[WIDTH];
    assign m_tkeep     = '1;
    assign m_tstrb     = '1;
    assign busy        = (state_q == RUN) || (cnt_q != 2'd0);
    assign frame_count = fc_q;

    // Frame control: latch length at frame start, count accepted beats, remember pending flushes.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        if (state_q == IDLE) begin
            if (enable) begin
                len_d   = (frame_len == '0) ? ONE : frame_len;
                beat_d  = '0;
                state_d = RUN;
            end
        end else if (push) begin
            if (last_in) begin
                beat_d = '0;
                pend_d = 1'b0;
                if (enable) len_d = (frame_len == '0) ? ONE : frame_len;
                else state_d = IDLE;
            end else begin
                beat_d = beat_q + ONE;
            end
        end else if (flush) begin
            pend_d = 1'b1;
        end
    end

    // Skid buffer: e0 is the head driving the outputs; ready is precomputed from next occupancy.
    always_comb begin
        wr_idx = cnt_q - {1'b0, pop};
        e0_d   = pop ? e1_q : e0_q;
        e1_d   = e1_q;
        if (push && wr_idx == 2'd0) e0_d = entry_in;
        if (push && wr_idx == 2'd1) e1_d = entry_in;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        rdy_d  = (state_d == RUN) && (cnt_d != 2'd2);
        fc_d   = fc_q + CNT_WIDTH'(pop && e0_q[WIDTH]);
    end

    // State registers; reset discards buffered beats without emitting a partial tlast.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= ONE;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            fc_q    <= fc_d;
        end
    end
endmodule

// File: tb/tb_axis_framer.sv
// tb_axis_framer: scoreboard bench for axis_framer (m_tuser checked when AXIS_FRAMER_TUSER_SOF_EN is defined).
module tb_axis_framer;
    logic        clk, reset, enable, flush, s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, busy;
    logic [15:0] frame_len;
    logic [31:0] s_tdata, m_tdata;
    logic [3:0]  m_tkeep, m_tstrb, frame_count;
`ifdef AXIS_FRAMER_TUSER_SOF_EN
    logic        m_tuser;
`endif
    logic        rdy_cfg, bp_mode;
    int          checks, errors, cyc;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
        int          acc;
        logic        lat;
    } exp_t;
    exp_t sb[$];

    axis_framer #(.WIDTH(32), .LEN_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_len(frame_len), .flush(flush),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tstrb(m_tstrb),
`ifdef AXIS_FRAMER_TUSER_SOF_EN
        .m_tuser(m_tuser),
`endif
        .busy(busy), .frame_count(frame_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // m_tready driver: fixed level, or toggling 1010... in backpressure mode
    initial begin
        m_tready = 0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_mode ? ~m_tready : rdy_cfg;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output monitor: pops scoreboard on each downstream transfer, checks hold stability under stall
    initial begin
        logic        stall, hl;
        logic [31:0] hd;
        exp_t        e;
        stall = 0;
        hl = 0;
        hd = 0;
        forever begin
            @(negedge clk);
            if (reset) stall = 0;
            else begin
                if (stall) begin
                    checks++;
                    if (!m_tvalid || m_tdata !== hd || m_tlast !== hl) begin
                        errors++;
                        $display("FAIL hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b", m_tvalid, m_tdata, m_tlast, hd, hl);
                    end
                end
                stall = m_tvalid && !m_tready;
                hd = m_tdata;
                hl = m_tlast;
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected output data=%h last=%0b, required none", m_tdata, m_tlast);
                    end else begin
                        e = sb.pop_front();
                        if (m_tdata !== e.d || m_tlast !== e.l) begin
                            errors++;
                            $display("FAIL beat: data=%h last=%0b, required data=%h last=%0b", m_tdata, m_tlast, e.d, e.l);
                        end
`ifdef AXIS_FRAMER_TUSER_SOF_EN
                        checks++;
                        if (m_tuser !== e.u) begin
                            errors++;
                            $display("FAIL tuser: data=%h tuser=%0b, required %0b", e.d, m_tuser, e.u);
                        end
`endif
                        if (e.lat) begin
                            checks++;
                            if (cyc != e.acc + 1) begin
                                errors++;
                                $display("FAIL latency: data=%h out cycle %0d, required %0d", e.d, cyc, e.acc + 1);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last, input logic user,
                             input logic fl, input logic lat, output int acc);
        int   w;
        logic done;
        w = 0;
        done = 0;
        acc = -1;
        s_tvalid = 1;
        s_tdata = d;
        flush = fl;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                sb.push_back('{d, last, user, cyc, lat});
                acc = cyc;
                done = 1;
            end else if (++w > 200) begin
                checks++;
                errors++;
                $display("FAIL accept: data=%h not accepted in 200 cycles, required accept", d);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        flush = 0;
    endtask

    task automatic do_reset();
        s_tvalid = 0;
        flush = 0;
        enable = 0;
        bp_mode = 0;
        rdy_cfg = 1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic drain(input int exp_fc);
        int w;
        w = 0;
        while ((sb.size() != 0 || m_tvalid) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (sb.size() != 0 || m_tvalid) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, m_tvalid=%0b, required 0", sb.size(), m_tvalid);
        end
        checks++;
        if (frame_count !== 4'(exp_fc)) begin
            errors++;
            $display("FAIL frame_count: got %0d, required %0d", frame_count, 4'(exp_fc));
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_tready !== 0 || m_tvalid !== 0 || m_tlast !== 0 || m_tdata !== 0 || busy !== 0 || frame_count !== 0) begin
            errors++;
            $display("FAIL reset: rdy=%0b vld=%0b last=%0b data=%h busy=%0b fc=%0d, required all 0",
                     s_tready, m_tvalid, m_tlast, m_tdata, busy, frame_count);
        end
        checks++;
        if (m_tkeep !== 4'hF || m_tstrb !== 4'hF) begin
            errors++;
            $display("FAIL keep_strb: keep=%h strb=%h, required F F", m_tkeep, m_tstrb);
        end
    endtask

    task automatic test_basic();
        int a, first, lst;
        do_reset();
        frame_len = 4;
        enable = 1;
        first = 0;
        lst = 0;
        for (int i = 0; i < 12; i++) begin
            send_beat(i, i % 4 == 3, i % 4 == 0, 0, 1, a);
            if (i == 0) first = a;
            lst = a;
        end
        s_tvalid = 0;
        checks++;
        if (lst - first != 11) begin
            errors++;
            $display("FAIL throughput: 12 beats accepted over %0d cycles, required 11", lst - first);
        end
        drain(3);
    endtask

    task automatic test_backpressure();
        int a;
        do_reset();
        frame_len = 8;
        enable = 1;
        bp_mode = 1;
        for (int i = 0; i < 32; i++) send_beat(i, i % 8 == 7, i % 8 == 0, 0, 0, a);
        s_tvalid = 0;
        drain(4);
        bp_mode = 0;
    endtask

    task automatic test_flush();
        int a;
        do_reset();
        frame_len = 10;
        enable = 1;
        for (int i = 0; i < 3; i++) send_beat(i, 0, i == 0, 0, 0, a);
        s_tvalid = 0;
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        send_beat(3, 1, 0, 0, 0, a);
        for (int i = 0; i < 10; i++) send_beat(16 + i, i == 9, i == 0, i == 9, 0, a);
        for (int i = 0; i < 2; i++) send_beat(32 + i, 0, i == 0, 0, 0, a);
        s_tvalid = 0;
        drain(2);
        do_reset();
        frame_len = 10;
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        enable = 1;
        for (int i = 0; i < 10; i++) send_beat(64 + i, i == 9, i == 0, 0, 0, a);
        s_tvalid = 0;
        drain(1);
    endtask

    task automatic test_edges();
        int a;
        do_reset();
        frame_len = 0;
        enable = 1;
        for (int i = 0; i < 3; i++) send_beat(i, 1, 1, 0, 0, a);
        s_tvalid = 0;
        drain(3);
        do_reset();
        frame_len = 4;
        enable = 1;
        send_beat(100, 0, 1, 0, 0, a);
        frame_len = 6;
        for (int i = 1; i < 10; i++) send_beat(100 + i, i == 3 || i == 9, i == 4, 0, 0, a);
        s_tvalid = 0;
        drain(2);
        do_reset();
        frame_len = 4;
        enable = 1;
        send_beat(200, 0, 1, 0, 0, a);
        send_beat(201, 0, 0, 0, 0, a);
        enable = 0;
        send_beat(202, 0, 0, 0, 0, a);
        send_beat(203, 1, 0, 0, 0, a);
        s_tvalid = 0;
        drain(1);
        checks++;
        if (s_tready !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL enable_drop: s_tready=%0b busy=%0b, required 0 0", s_tready, busy);
        end
        s_tvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_tready !== 0) begin
                errors++;
                $display("FAIL idle_ready: s_tready=%0b with enable=0, required 0", s_tready);
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 0;
    endtask

    task automatic test_reset_mid();
        int a;
        do_reset();
        frame_len = 4;
        enable = 1;
        for (int i = 0; i < 4; i++) send_beat(i, i == 3, i == 0, 0, 0, a);
        s_tvalid = 0;
        drain(1);
        rdy_cfg = 0;
        @(posedge clk);
        #1;
        send_beat(100, 0, 1, 0, 0, a);
        send_beat(101, 0, 0, 0, 0, a);
        s_tvalid = 0;
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1 || s_tready !== 0) begin
            errors++;
            $display("FAIL buffer_full: m_tvalid=%0b s_tready=%0b, required 1 0", m_tvalid, s_tready);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if (m_tvalid !== 0 || s_tready !== 0 || frame_count !== 0) begin
            errors++;
            $display("FAIL async_reset: m_tvalid=%0b s_tready=%0b fc=%0d, required 0 0 0", m_tvalid, s_tready, frame_count);
        end
        sb.delete();
        @(posedge clk);
        #3;
        reset = 0;
        rdy_cfg = 1;
        for (int i = 0; i < 4; i++) send_beat(200 + i, i == 3, i == 0, 0, 0, a);
        s_tvalid = 0;
        drain(1);
    endtask

    task automatic test_wrap();
        int a;
        do_reset();
        frame_len = 1;
        enable = 1;
        for (int i = 0; i < 17; i++) send_beat(i, 1, 1, 0, 0, a);
        s_tvalid = 0;
        drain(17);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1;
        enable = 0;
        flush = 0;
        frame_len = 0;
        s_tvalid = 0;
        s_tdata = 0;
        rdy_cfg = 1;
        bp_mode = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_edges();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
